// File: rtl/spi_ram_arbiter.sv
// Shares one async-read RAM port between SPI_Slave command words and a local host.
// Ports: clk/rst_n, rx_data/rx_valid in, tx_data/tx_valid out, host_* handshake, mem_* RAM port.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [DATA_W-1:0]    host_wdata,
  output logic                 host_gnt,
  output logic [DATA_W-1:0]    host_rdata,
  output logic                 host_rvalid,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_we,
  input  logic [DATA_W-1:0]    mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPI_WR  = 2'd1,
    SPI_RD  = 2'd2,
    HOST_OP = 2'd3
  } state_t;

  localparam logic [1:0] C_WADDR = 2'b00;
  localparam logic [1:0] C_WDATA = 2'b01;
  localparam logic [1:0] C_RADDR = 2'b10;
  localparam logic [1:0] C_RDATA = 2'b11;

  localparam logic INC = (AUTO_INC != 0);

  state_t state;
  state_t nxt;

  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [DATA_W-1:0]    data_q;
  logic                 pend;
  logic                 op_rd;

  // last driven port values, so the bus holds while idle
  logic [ADDR_SIZE-1:0] addr_q;
  logic [DATA_W-1:0]    wdata_q;

  logic [1:0] cmd;
  logic       host_rd;

  assign cmd = rx_data[9:8];

  // a pending SPI command always wins; the host is only
  // considered once nothing is pending
  always_comb begin
    nxt = IDLE;
    if (pend) begin
      nxt = op_rd ? SPI_RD : SPI_WR;
    end else if (host_req) begin
      nxt = HOST_OP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    host_gnt  = 1'b0;
    unique case (state)
      SPI_WR: begin
        mem_addr  = wr_addr;
        mem_wdata = data_q;
        mem_we    = 1'b1;
      end
      SPI_RD: begin
        mem_addr = rd_addr;
      end
      HOST_OP: begin
        host_gnt = 1'b1;
        mem_addr = host_addr;
        if (host_we) begin
          mem_wdata = host_wdata;
          mem_we    = host_req;
        end
      end
      default: begin
      end
    endcase
  end

  assign host_rd = (state == HOST_OP) && !host_we && host_req;

  // command capture; a fresh capture overrides both the
  // pend clear and any auto-increment landing on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
      data_q  <= '0;
      pend    <= 1'b0;
      op_rd   <= 1'b0;
    end else begin
      if (pend) begin
        pend <= 1'b0;
      end
      if (INC && state == SPI_WR) begin
        wr_addr <= wr_addr + ADDR_SIZE'(1);
      end
      if (INC && state == SPI_RD) begin
        rd_addr <= rd_addr + ADDR_SIZE'(1);
      end
      if (rx_valid) begin
        unique case (cmd)
          C_WADDR: wr_addr <= ADDR_SIZE'(rx_data[7:0]);
          C_RADDR: rd_addr <= ADDR_SIZE'(rx_data[7:0]);
          C_WDATA: begin
            data_q <= DATA_W'(rx_data[7:0]);
            op_rd  <= 1'b0;
            pend   <= 1'b1;
          end
          C_RDATA: begin
            op_rd <= 1'b1;
            pend  <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= (state == SPI_RD);
      if (state == SPI_RD) begin
        tx_data <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= host_rd;
      if (host_rd) begin
        host_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: directed steps plus randomized host/SPI
// contention, checked against a transaction-level RAM model.
module tb_spi_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  logic [9:0] rx_data_b;
  logic       rx_valid_b;
  logic [7:0] tx_data_b;
  logic       tx_valid_b;
  logic       hreq_b;
  logic       hwe_b;
  logic [7:0] haddr_b;
  logic [7:0] hwdata_b;
  logic       hgnt_b;
  logic [7:0] hrdata_b;
  logic       hrvalid_b;
  logic [7:0] mem_addr_b;
  logic [7:0] mem_wdata_b;
  logic       mem_we_b;
  logic [7:0] mem_rdata_b;

  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];
  logic [7:0] mdl   [256];

  logic       ld_we;
  logic [7:0] ld_a;
  logic [7:0] ld_d;

  int checks = 0;
  int errors = 0;

  spi_ram_arbiter #(.ADDR_SIZE(8), .DATA_W(8), .AUTO_INC(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  spi_ram_arbiter #(.ADDR_SIZE(8), .DATA_W(8), .AUTO_INC(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .host_req(hreq_b), .host_we(hwe_b),
    .host_addr(haddr_b), .host_wdata(hwdata_b),
    .host_gnt(hgnt_b), .host_rdata(hrdata_b),
    .host_rvalid(hrvalid_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_we(mem_we_b), .mem_rdata(mem_rdata_b)
  );

  assign mem_rdata   = ram_a[mem_addr];
  assign mem_rdata_b = ram_b[mem_addr_b];

  always @(posedge clk) begin
    if (ld_we) ram_a[ld_a] <= ld_d;
    else if (mem_we) ram_a[mem_addr] <= mem_wdata;
  end

  always @(posedge clk) begin
    if (mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic spi_a(input logic [9:0] w);
    tick();
    rx_data  = w;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic spi_b(input logic [9:0] w);
    tick();
    rx_data_b  = w;
    rx_valid_b = 1'b1;
    tick();
    rx_valid_b = 1'b0;
  endtask

  task automatic cfg_a(input logic [9:0] w);
    spi_a(w);
    idle(10);
  endtask

  task automatic cfg_b(input logic [9:0] w);
    spi_b(w);
    idle(10);
  endtask

  initial begin
    logic [7:0] ra, wa, d, ha, hd, exp_tx, exp_h, txv, rv;
    logic       hwe;
    int gl, txc, txs, rvs, bad;

    rst_n      = 1'b0;
    rx_data    = '0;
    rx_valid   = 1'b0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    rx_data_b  = '0;
    rx_valid_b = 1'b0;
    hreq_b     = 1'b0;
    hwe_b      = 1'b0;
    haddr_b    = '0;
    hwdata_b   = '0;
    ld_we      = 1'b0;
    ld_a       = '0;
    ld_d       = '0;

    // preload RAM A with random contents while in reset
    for (int i = 0; i < 256; i++) begin
      ld_a  = 8'(i);
      ld_d  = 8'($urandom);
      mdl[i] = ld_d;
      ld_we = 1'b1;
      tick();
    end
    ld_we = 1'b0;

    @(negedge clk);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_b_mem_we", mem_we_b, 0);
    tick();
    rst_n = 1'b1;
    idle(3);

    // SPI write: address then data
    cfg_a(10'h005);
    spi_a(10'h1A5);
    tick();
    @(negedge clk);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 8'h05);
    chk("wr_mem_wdata", mem_wdata, 8'hA5);
    chk("wr_host_gnt", host_gnt, 0);
    tick();
    @(negedge clk);
    mdl[5] = 8'hA5;
    chk("wr_done_we", mem_we, 0);
    chk("idle_hold_addr", mem_addr, 8'h05);
    chk("idle_hold_wdata", mem_wdata, 8'hA5);
    chk("wr_ram5", ram_a[5], mdl[5]);
    idle(10);

    // SPI read of the same address
    cfg_a(10'h205);
    spi_a(10'h300);
    tick();
    @(negedge clk);
    chk("rd_tx_early", tx_valid, 0);
    chk("rd_mem_addr", mem_addr, 8'h05);
    chk("rd_mem_we", mem_we, 0);
    tick();
    @(negedge clk);
    chk("rd_tx_valid", tx_valid, 1);
    chk("rd_tx_data", tx_data, mdl[5]);
    tick();
    @(negedge clk);
    chk("rd_tx_pulse", tx_valid, 0);
    idle(10);

    // host read waits behind a pending SPI write
    spi_a(10'h1C3);
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h05;
    tick();
    @(negedge clk);
    chk("ho_spi_first_we", mem_we, 1);
    chk("ho_spi_first_gnt", host_gnt, 0);
    chk("ho_spi_wdata", mem_wdata, 8'hC3);
    tick();
    @(negedge clk);
    mdl[5] = 8'hC3;
    chk("ho_gnt", host_gnt, 1);
    chk("ho_gnt_we", mem_we, 0);
    chk("ho_gnt_addr", mem_addr, 8'h05);
    tick();
    host_req = 1'b0;
    @(negedge clk);
    chk("ho_rvalid", host_rvalid, 1);
    chk("ho_rdata", host_rdata, mdl[5]);
    tick();
    @(negedge clk);
    chk("ho_rvalid_pulse", host_rvalid, 0);
    idle(10);

    // reset in the middle of an SPI write
    spi_a(10'h15A);
    tick();
    @(negedge clk);
    chk("mid_we_before", mem_we, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_gnt", host_gnt, 0);
    chk("mid_rst_rvalid", host_rvalid, 0);
    tick();
    chk("mid_rst_nowrite", ram_a[5], mdl[5]);
    rst_n = 1'b1;
    idle(10);
    // address registers are back at 0
    spi_a(10'h300);
    tick();
    tick();
    @(negedge clk);
    chk("post_rst_rd_valid", tx_valid, 1);
    chk("post_rst_rd_data", tx_data, mdl[0]);
    idle(10);

    // auto-increment with wrap on the second instance
    cfg_b(10'h0FF);
    cfg_b(10'h111);
    cfg_b(10'h122);
    chk("inc_ram_ff", ram_b[255], 8'h11);
    chk("inc_ram_00", ram_b[0], 8'h22);
    cfg_b(10'h2FF);
    spi_b(10'h300);
    tick();
    tick();
    @(negedge clk);
    chk("inc_rd0_valid", tx_valid_b, 1);
    chk("inc_rd0_data", tx_data_b, 8'h11);
    idle(10);
    spi_b(10'h300);
    tick();
    tick();
    @(negedge clk);
    chk("inc_rd1_data", tx_data_b, 8'h22);
    idle(10);

    // randomized host/SPI-read contention on the same edge
    for (int it = 0; it < 50; it++) begin
      wa = 8'($urandom);
      d  = 8'($urandom);
      ra = 8'($urandom);
      cfg_a({2'b00, wa});
      cfg_a({2'b01, d});
      mdl[wa] = d;
      cfg_a({2'b10, ra});
      ha  = (it % 4 == 0) ? ra : 8'($urandom);
      hwe = 1'($urandom);
      hd  = 8'($urandom);
      // host was asking before the SPI read could pend, so it goes first
      exp_h = mdl[ha];
      if (hwe) mdl[ha] = hd;
      exp_tx = mdl[ra];
      idle($urandom_range(0, 3));
      tick();
      rx_data    = 10'h300;
      rx_valid   = 1'b1;
      host_req   = 1'b1;
      host_we    = hwe;
      host_addr  = ha;
      host_wdata = hd;
      gl = -1; txc = -1; txs = 0; rvs = 0;
      txv = '0; rv = '0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (host_gnt && gl < 0) gl = c;
        if (tx_valid) begin
          txs++;
          txc = c;
          txv = tx_data;
        end
        if (host_rvalid) begin
          rvs++;
          rv = host_rdata;
        end
        tick();
        rx_valid = 1'b0;
        if (gl >= 0) host_req = 1'b0;
      end
      host_req = 1'b0;
      chk("rnd_gnt_within3", 32'(gl >= 1 && gl <= 3), 1);
      chk("rnd_tx_count", txs, 1);
      chk("rnd_tx_lat", txc, 3);
      chk("rnd_tx_data", txv, exp_tx);
      chk("rnd_rvalid_count", rvs, hwe ? 0 : 1);
      if (!hwe) chk("rnd_host_rdata", rv, exp_h);
      idle($urandom_range(2, 8));
    end

    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (ram_a[i] !== mdl[i]) bad++;
    end
    chk("final_ram_image", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
